// File: rtl/charlie7x5_scan_ctrl_if.sv
// Wishbone-B4 classic register port of the charlieplexed 7x5 scan controller.
interface charlie7x5_scan_ctrl_if;
  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 8;

  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_we_i;
  logic [ADR_W-1:0] wb_adr_i;
  logic [DAT_W-1:0] wb_dat_i;
  logic [DAT_W-1:0] wb_dat_o;
  logic             wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/charlie7x5_scan_ctrl.sv
// Charlieplexed 7x5 LED scanner: double-buffered framebuffer, per-row dead time,
// 8-bit PWM drive window, Wishbone register access.
module charlie7x5_scan_ctrl #(
  parameter int unsigned DEAD_TICKS = 16,
  parameter int unsigned PWM_STEP   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  charlie7x5_scan_ctrl_if.slave        wb,
  output logic [6:0]                   charlie7x5_o,
  output logic [6:0]                   charlie7x5_oe,
  output logic                         frame_o
);

  localparam int unsigned ROWS   = 7;
  localparam int unsigned COLS   = 5;
  localparam int unsigned PINS   = 7;
  localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam int unsigned SUB_W  = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PWM_STEP - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e                    state_q, state_d;
  logic [DEAD_W-1:0]         dead_q, dead_d;
  logic [SUB_W-1:0]          sub_q, sub_d;
  logic [7:0]                step_q, step_d;
  logic [2:0]                row_q, row_d;
  logic [7:0]                duty_q, duty_d;
  logic [ROWS-1:0][COLS-1:0] back_q, back_d;
  logic [ROWS-1:0][COLS-1:0] front_q, front_d;
  logic                      en_q, en_d;
  logic                      pend_q, pend_d;
  logic [7:0]                bright_q, bright_d;
  logic [7:0]                frame_cnt_q, frame_cnt_d;
  logic                      frame_q, frame_d;
  logic                      ack_q, ack_d;
  logic [7:0]                dat_q, dat_d;
  logic [PINS-1:0]           pin_o_q, pin_o_d;
  logic [PINS-1:0]           pin_oe_q, pin_oe_d;

  logic                      bus_req;
  logic                      bus_wr;
  logic                      boundary;
  logic [7:0]                rd_data;
  logic [3:0]                pin;

  assign bus_req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign bus_wr  = bus_req & wb.wb_we_i;

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (wb.wb_adr_i)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
        rd_data = 8'(back_q[wb.wb_adr_i[2:0]]);
      4'h8:    rd_data = {6'b0, pend_q, en_q};
      4'h9:    rd_data = bright_q;
      4'hA:    rd_data = frame_cnt_q;
      default: rd_data = '0;
    endcase
  end

  // Scan FSM: next state and slot counters
  always_comb begin
    state_d  = state_q;
    dead_d   = dead_q;
    sub_d    = sub_q;
    step_d   = step_q;
    row_d    = row_q;
    duty_d   = duty_q;
    boundary = 1'b0;
    if (!en_q) begin
      state_d = IDLE;
      dead_d  = '0;
      sub_d   = '0;
      step_d  = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          dead_d  = '0;
        end
        BLANK: begin
          if (dead_q == DEAD_LAST) begin
            state_d = DRIVE;
            dead_d  = '0;
            sub_d   = '0;
            step_d  = '0;
            duty_d  = bright_q;
          end else begin
            dead_d = dead_q + DEAD_W'(1);
          end
        end
        DRIVE: begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (step_q == 8'hFF) begin
              state_d = BLANK;
              if (row_q == 3'(ROWS - 1)) begin
                row_d    = '0;
                boundary = 1'b1;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              step_d = step_q + 8'd1;
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus side effects and the frame-boundary buffer swap; a same-edge write lands after the copy
  always_comb begin
    back_d      = back_q;
    front_d     = front_q;
    en_d        = en_q;
    pend_d      = pend_q;
    bright_d    = bright_q;
    frame_cnt_d = frame_cnt_q;
    frame_d     = boundary;
    ack_d       = bus_req;
    dat_d       = (bus_req && !wb.wb_we_i) ? rd_data : '0;
    if (boundary) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (pend_q) begin
        front_d = back_q;
        pend_d  = 1'b0;
      end
    end
    if (bus_wr) begin
      case (wb.wb_adr_i)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
          back_d[wb.wb_adr_i[2:0]] = wb.wb_dat_i[4:0];
        4'h8: begin
          en_d = wb.wb_dat_i[0];
          if (wb.wb_dat_i[1]) pend_d = 1'b1;
        end
        4'h9:    bright_d = wb.wb_dat_i;
        default: ;
      endcase
    end
  end

  // Pin pattern: anode on pin r, cathode k on pin (r+1+k) mod 7, only in the lit part of DRIVE
  always_comb begin
    pin_o_d  = '0;
    pin_oe_d = '0;
    pin      = '0;
    if (en_q && state_q == DRIVE && step_q < duty_q && front_q[row_q] != '0) begin
      for (int k = 0; k < COLS; k++) begin
        pin = 4'(row_q) + 4'(k) + 4'd1;
        if (pin >= 4'(PINS)) pin = pin - 4'(PINS);
        if (front_q[row_q][k]) pin_oe_d[pin[2:0]] = 1'b1;
      end
      pin_oe_d[row_q] = 1'b1;
      pin_o_d[row_q]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dead_q      <= '0;
      sub_q       <= '0;
      step_q      <= '0;
      row_q       <= '0;
      duty_q      <= '0;
      back_q      <= '0;
      front_q     <= '0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      bright_q    <= 8'hFF;
      frame_cnt_q <= '0;
      frame_q     <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      pin_o_q     <= '0;
      pin_oe_q    <= '0;
    end else begin
      state_q     <= state_d;
      dead_q      <= dead_d;
      sub_q       <= sub_d;
      step_q      <= step_d;
      row_q       <= row_d;
      duty_q      <= duty_d;
      back_q      <= back_d;
      front_q     <= front_d;
      en_q        <= en_d;
      pend_q      <= pend_d;
      bright_q    <= bright_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      pin_o_q     <= pin_o_d;
      pin_oe_q    <= pin_oe_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign charlie7x5_o  = pin_o_q;
  assign charlie7x5_oe = pin_oe_q;
  assign frame_o       = frame_q;

endmodule

// File: tb/tb_charlie7x5_scan_ctrl.sv
// Directed bench for charlie7x5_scan_ctrl with DEAD_TICKS=2, PWM_STEP=1 (258-clock row slot).
module tb_charlie7x5_scan_ctrl;

  localparam int unsigned DEAD       = 2;
  localparam int unsigned STEP       = 1;
  localparam int          SLOT       = DEAD + 256 * STEP;
  localparam int          FRAME_CLKS = 7 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pin_o;
  logic [6:0] pin_oe;
  logic       frame_o;

  int checks = 0;
  int errors = 0;
  int waited;
  int lit_n;
  int first_lit;
  logic [6:0] cap_oe;
  logic [6:0] cap_o;
  logic [7:0] exp_rd;

  charlie7x5_scan_ctrl_if wb ();

  charlie7x5_scan_ctrl #(.DEAD_TICKS(DEAD), .PWM_STEP(STEP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb),
    .charlie7x5_o  (pin_o),
    .charlie7x5_oe (pin_oe),
    .frame_o       (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pin safety holds on every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("no_high_when_hiz", 32'(pin_o & ~pin_oe), 32'h0);
      chk("single_high_pin", 32'($countones(pin_o) <= 1), 32'h1);
    end
  end

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = a;    wb.wb_dat_i = d;
    @(negedge clk);
    chk("wr_ack", 32'(wb.wb_ack_o), 32'h1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    @(negedge clk);
    chk("wr_ack_single", 32'(wb.wb_ack_o), 32'h0);
  endtask

  task automatic wb_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = a;
    @(negedge clk);
    chk("rd_ack", 32'(wb.wb_ack_o), 32'h1);
    chk(tag, 32'(wb.wb_dat_o), 32'(exp));
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("rd_ack_single", 32'(wb.wb_ack_o), 32'h0);
    chk("rd_dat_idle", 32'(wb.wb_dat_o), 32'h0);
  endtask

  task automatic wait_frame(input int bound);
    waited = 0;
    lit_n  = 0;
    do begin
      @(negedge clk);
      waited++;
      if (pin_oe != 7'h0) lit_n++;
    end while (frame_o !== 1'b1 && waited < bound);
    chk("frame_pulse_seen", 32'(frame_o), 32'h1);
  endtask

  // Observe the full slot of row r; elapsed = negedges already spent since the frame pulse sample
  task automatic measure_row(input int r, input int elapsed, input logic [6:0] eoe,
                             input logic [6:0] eo, input int eduty, input string tag);
    int first, last, lit, bad;
    first = -1; last = -1; lit = 0; bad = 0;
    repeat (r * SLOT - elapsed) @(negedge clk);
    for (int i = 1; i <= SLOT; i++) begin
      @(negedge clk);
      if (pin_oe != 7'h0) begin
        lit++;
        if (first < 0) first = i;
        last = i;
        if (pin_oe !== eoe || pin_o !== eo) bad++;
      end
    end
    chk({tag, "_lit_clks"}, 32'(lit), 32'(eduty));
    chk({tag, "_pattern"}, 32'(bad), 32'h0);
    chk({tag, "_first"}, 32'(first), (eduty > 0) ? 32'd3 : 32'hFFFF_FFFF);
    chk({tag, "_last"}, 32'(last), (eduty > 0) ? 32'(2 + eduty) : 32'hFFFF_FFFF);
  endtask

  initial begin
    rst_n = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(pin_oe), 32'h0);
    chk("rst_o", 32'(pin_o), 32'h0);
    chk("rst_ack", 32'(wb.wb_ack_o), 32'h0);
    chk("rst_frame_o", 32'(frame_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while row 0 is being driven
    wb_write(4'h0, 8'h01);
    wb_write(4'h9, 8'h10);
    wb_write(4'h8, 8'h03);
    wait_frame(2 * FRAME_CLKS);
    chk("t1_first_frame_dark", 32'(lit_n), 32'h0);
    repeat (10) @(negedge clk);
    chk("t1_row0_oe", 32'(pin_oe), 32'h03);
    rst_n = 1'b0;
    #1;
    chk("t1_async_oe", 32'(pin_oe), 32'h0);
    chk("t1_async_o", 32'(pin_o), 32'h0);
    chk("t1_async_ack", 32'(wb.wb_ack_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(4'h9, 8'hFF, "t1_bright_rst");
    wb_read(4'hA, 8'h00, "t1_frame_rst");
    wb_read(4'h8, 8'h00, "t1_ctrl_rst");
    wb_read(4'h0, 8'h00, "t1_row0_rst");

    // Commit becomes visible only after the first boundary; full duty lights 255 of 256 steps
    wb_write(4'h0, 8'h01);
    wb_write(4'h8, 8'h03);
    wb_write(4'h9, 8'hFF);
    wait_frame(2 * FRAME_CLKS);
    chk("t2_first_frame_dark", 32'(lit_n), 32'h0);
    measure_row(0, 0, 7'h03, 7'h01, 255, "t2_row0");
    wb_read(4'h8, 8'h01, "t2_pend_cleared");

    // Quarter duty; row 3 full uses pins 0,1,3,4,5,6; row 4 = 0x03 uses pins 4,5,6
    wb_write(4'h9, 8'h40);
    wb_write(4'h3, 8'h1F);
    wb_write(4'h4, 8'h03);
    wb_write(4'h8, 8'h03);
    wait_frame(FRAME_CLKS + 10);
    chk("t3_wait_to_boundary", 32'(waited), 32'(FRAME_CLKS - SLOT - 10));
    measure_row(0, 0, 7'h03, 7'h01, 64, "t3_row0");
    measure_row(3, SLOT, 7'h7B, 7'h08, 64, "t3_row3");
    measure_row(4, 4 * SLOT, 7'h70, 7'h10, 64, "t3_row4");
    wb_read(4'hA, 8'h02, "t3_frame_a");
    wait_frame(FRAME_CLKS + 10);
    chk("t3_wait_rest", 32'(waited), 32'(FRAME_CLKS - 5 * SLOT - 2));
    wb_read(4'hA, 8'h03, "t3_frame_b");
    wait_frame(FRAME_CLKS + 10);
    chk("t3_frame_period", 32'(waited), 32'(FRAME_CLKS - 2));

    // Boundary-edge writes: row write misses the swap, commit survives to the next boundary
    wb_write(4'h8, 8'h03);
    repeat (FRAME_CLKS - 1 - 2) @(negedge clk);
    wb_write(4'h2, 8'h05);
    measure_row(2, 1, 7'h2C, 7'h04, 0, "t4_row2_held");
    wb_read(4'h8, 8'h01, "t4_pend_after_swap");
    repeat (FRAME_CLKS - 1 - (3 * SLOT + 2)) @(negedge clk);
    wb_write(4'h8, 8'h03);
    wb_read(4'h8, 8'h03, "t4_pend_kept");
    measure_row(2, 3, 7'h2C, 7'h04, 0, "t4_row2_still");
    wait_frame(FRAME_CLKS + 10);
    chk("t4_wait_to_boundary", 32'(waited), 32'(FRAME_CLKS - 3 * SLOT));
    measure_row(2, 0, 7'h2C, 7'h04, 64, "t4_row2_swapped");
    wb_read(4'h8, 8'h01, "t4_pend_done");

    // Disable mid row 4, then restart from row 0
    repeat (4 * SLOT + 10 - (3 * SLOT + 2)) @(negedge clk);
    chk("t5_row4_lit_oe", 32'(pin_oe), 32'h70);
    chk("t5_row4_lit_o", 32'(pin_o), 32'h10);
    wb_write(4'h8, 8'h00);
    chk("t5_dark_oe", 32'(pin_oe), 32'h0);
    chk("t5_dark_o", 32'(pin_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stays_dark", 32'(pin_oe), 32'h0);
    end
    wb_read(4'h8, 8'h00, "t5_ctrl_off");
    wb_write(4'h8, 8'h01);
    first_lit = -1;
    cap_oe = '0;
    cap_o  = '0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (pin_oe != 7'h0 && first_lit < 0) begin
        first_lit = j;
        cap_oe = pin_oe;
        cap_o  = pin_o;
      end
    end
    chk("t5_restart_latency", 32'(first_lit), 32'd3);
    chk("t5_restart_row0_oe", 32'(cap_oe), 32'h03);
    chk("t5_restart_row0_o", 32'(cap_o), 32'h01);

    // Back-to-back write/read over the whole address space with strobe held
    wb_write(4'h8, 8'h00);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    for (int a = 0; a < 16; a++) begin
      wb.wb_we_i  = 1'b1;
      wb.wb_adr_i = 4'(a);
      wb.wb_dat_i = (a == 8) ? 8'hFE : 8'hFF;
      @(negedge clk);
      chk("t6_wr_ack", 32'(wb.wb_ack_o), 32'h1);
      @(negedge clk);
      chk("t6_wr_gap", 32'(wb.wb_ack_o), 32'h0);
      wb.wb_we_i = 1'b0;
      case (a)
        0, 1, 2, 3, 4, 5, 6: exp_rd = 8'h1F;
        8:                   exp_rd = 8'h02;
        9:                   exp_rd = 8'hFF;
        10:                  exp_rd = 8'h07;
        default:             exp_rd = 8'h00;
      endcase
      @(negedge clk);
      chk("t6_rd_ack", 32'(wb.wb_ack_o), 32'h1);
      chk($sformatf("t6_rd_adr%0d", a), 32'(wb.wb_dat_o), 32'(exp_rd));
      @(negedge clk);
      chk("t6_rd_gap", 32'(wb.wb_ack_o), 32'h0);
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t6_idle_ack", 32'(wb.wb_ack_o), 32'h0);
    chk("t6_idle_oe", 32'(pin_oe), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
